// File: rtl/message_validator_pkg.sv
// Shared constants and state encoding for the decrypted-message validator
// and the key-search logic that reuses its character check.
package message_validator_pkg;

    localparam int DEFAULT_MSG_LEN = 32;
    localparam int DEFAULT_ADDR_W  = 5;

    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_WAIT,
        CHECK,
        INCR,
        DONE
    } state_e;

endpackage

// File: rtl/message_validator_if.sv
// Validator-side bundle: start/result handshake towards the key-search
// controller plus the read-only port onto the decrypted message RAM.
interface message_validator_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic [7:0]        ram_read_data;
    logic [ADDR_W-1:0] ram_address;
    logic              busy;
    logic              finish;
    logic              valid;
    logic [ADDR_W-1:0] bad_index;
    logic [7:0]        bad_char;

    modport slave (
        input  start, ram_read_data,
        output ram_address, busy, finish, valid, bad_index, bad_char
    );

    modport master (
        output start, ram_read_data,
        input  ram_address, busy, finish, valid, bad_index, bad_char
    );

endinterface

// File: rtl/message_validator_char_is_legal.sv
// Combinational plaintext test: lowercase a..z, optionally also space.
module message_validator_char_is_legal
    import message_validator_pkg::*;
#(
    parameter bit ALLOW_SPACE = 1'b1
) (
    input  logic [7:0] char_in,
    output logic       legal
);

    always_comb begin
        legal = ((char_in >= CHAR_LO) && (char_in <= CHAR_HI)) ||
                (ALLOW_SPACE && (char_in == CHAR_SPACE));
    end

endmodule

// File: rtl/message_validator.sv
// Scans the decrypted message RAM after decryption and reports whether every
// byte is plaintext, plus the first offending index and byte.
module message_validator
    import message_validator_pkg::*;
#(
    parameter int MSG_LEN     = DEFAULT_MSG_LEN,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter bit ALLOW_SPACE = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    message_validator_if.slave bus
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [ADDR_W-1:0] bad_index_q, bad_index_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        bad_char_q, bad_char_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              finish_q, finish_d;
    logic              legal;

    message_validator_char_is_legal #(
        .ALLOW_SPACE(ALLOW_SPACE)
    ) u_char_is_legal (
        .char_in(data_q),
        .legal  (legal)
    );

    // Every byte costs READ, READ_WAIT, CHECK, INCR (4 clocks); CHECK records
    // the verdict and INCR is the single exit to DONE, so scan timing is uniform.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        data_d      = data_q;
        valid_d     = valid_q;
        bad_index_d = bad_index_q;
        bad_char_d  = bad_char_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = READ;
                    k_d         = '0;
                    valid_d     = 1'b0;
                    bad_index_d = '0;
                    bad_char_d  = '0;
                end
            end
            READ: begin
                state_d = READ_WAIT;
            end
            READ_WAIT: begin
                state_d = CHECK;
                data_d  = bus.ram_read_data;
            end
            CHECK: begin
                state_d = INCR;
                if (!legal) begin
                    valid_d     = 1'b0;
                    bad_index_d = k_q;
                    bad_char_d  = data_q;
                end else if (k_q == K_LAST) begin
                    valid_d = 1'b1;
                end
            end
            INCR: begin
                if (!legal || (k_q == K_LAST)) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                    k_d     = k_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ram_address_d = k_d;
        busy_d        = (state_d != IDLE) && (state_d != DONE);
        finish_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            ram_address_q <= '0;
            valid_q       <= 1'b0;
            bad_index_q   <= '0;
            bad_char_q    <= '0;
            busy_q        <= 1'b0;
            finish_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            ram_address_q <= ram_address_d;
            valid_q       <= valid_d;
            bad_index_q   <= bad_index_d;
            bad_char_q    <= bad_char_d;
            busy_q        <= busy_d;
            finish_q      <= finish_d;
        end
    end

    // The captured byte is pure datapath; it is always reloaded before use.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign bus.ram_address = ram_address_q;
    assign bus.busy        = busy_q;
    assign bus.finish      = finish_q;
    assign bus.valid       = valid_q;
    assign bus.bad_index   = bad_index_q;
    assign bus.bad_char    = bad_char_q;

endmodule

// File: tb/tb_message_validator.sv
// Directed scoreboard bench for message_validator: one DUT with space allowed,
// one without, both reading a shared message RAM model.
module tb_message_validator;

    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;

    typedef struct {
        logic              v;
        logic [ADDR_W-1:0] idx;
        logic [7:0]        ch;
        int                lat;
    } exp_t;

    logic clk;
    logic reset_n;
    logic [7:0] mem [MSG_LEN];
    exp_t sb [$];
    int total;
    int bad;
    int max_addr;

    message_validator_if #(.ADDR_W(ADDR_W)) bus0 ();
    message_validator_if #(.ADDR_W(ADDR_W)) bus1 ();

    message_validator #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W), .ALLOW_SPACE(1'b0)) dut0 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus0.slave)
    );

    message_validator #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W), .ALLOW_SPACE(1'b1)) dut1 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM: data for an address is ready by the second edge.
    always_ff @(posedge clk) begin
        bus0.ram_read_data <= mem[bus0.ram_address];
        bus1.ram_read_data <= mem[bus1.ram_address];
    end

    function automatic logic get_fin(input bit sel);
        return sel ? bus1.finish : bus0.finish;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? bus1.busy : bus0.busy;
    endfunction
    function automatic logic get_valid(input bit sel);
        return sel ? bus1.valid : bus0.valid;
    endfunction
    function automatic logic [ADDR_W-1:0] get_idx(input bit sel);
        return sel ? bus1.bad_index : bus0.bad_index;
    endfunction
    function automatic logic [7:0] get_ch(input bit sel);
        return sel ? bus1.bad_char : bus0.bad_char;
    endfunction
    function automatic logic [ADDR_W-1:0] get_addr(input bit sel);
        return sel ? bus1.ram_address : bus0.ram_address;
    endfunction
    function automatic logic [20:0] all_outs(input bit sel);
        return {get_busy(sel), get_fin(sel), get_valid(sel), get_idx(sel), get_ch(sel), get_addr(sel)};
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus1.start = v;
        else     bus0.start = v;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference scan: first byte outside a..z (and space when allowed) wins.
    function automatic exp_t model(input bit allow_sp);
        exp_t e;
        e.v   = 1'b1;
        e.idx = '0;
        e.ch  = '0;
        e.lat = 4 * MSG_LEN;
        for (int i = 0; i < MSG_LEN; i++) begin
            logic [7:0] b;
            b = mem[i];
            if (!((b >= 8'h61 && b <= 8'h7A) || (allow_sp && b == 8'h20))) begin
                e.v   = 1'b0;
                e.idx = ADDR_W'(i);
                e.ch  = b;
                e.lat = 4 * i + 4;
                return e;
            end
        end
        return e;
    endfunction

    task automatic fill(input logic [7:0] b);
        for (int i = 0; i < MSG_LEN; i++) mem[i] = b;
    endtask

    task automatic compare_result(input bit sel, input string tag, input int n);
        exp_t e;
        e = sb.pop_front();
        check({tag, "_latency"}, 64'(n), 64'(e.lat));
        check({tag, "_valid"}, 64'(get_valid(sel)), 64'(e.v));
        check({tag, "_bad_index"}, 64'(get_idx(sel)), 64'(e.idx));
        check({tag, "_bad_char"}, 64'(get_ch(sel)), 64'(e.ch));
        check({tag, "_busy_in_done"}, 64'(get_busy(sel)), 64'd0);
    endtask

    task automatic run_scan(input bit sel, input string tag);
        exp_t e;
        exp_t held;
        int n;
        bit busy_ok;
        e = model(sel);
        sb.push_back(e);
        held = e;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        check({tag, "_cleared_on_start"}, {get_valid(sel), get_idx(sel), get_ch(sel)}, '0);
        n = 0;
        busy_ok = 1'b1;
        max_addr = int'(get_addr(sel));
        while (!get_fin(sel) && n < 300) begin
            if (!get_busy(sel)) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (int'(get_addr(sel)) > max_addr) max_addr = int'(get_addr(sel));
        end
        check({tag, "_busy_during_scan"}, 64'(busy_ok), 64'd1);
        compare_result(sel, tag, n);
        @(posedge clk);
        #1;
        check({tag, "_finish_one_cycle"}, 64'(get_fin(sel)), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_results_held"}, {get_valid(sel), get_idx(sel), get_ch(sel)},
              {held.v, held.idx, held.ch});
    endtask

    initial begin
        string msg;
        int n;
        int m;
        int idle_cnt;
        bit fin_seen;

        total = 0;
        bad = 0;
        reset_n = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        fill(8'h61);

        #1;
        check("reset_outputs_dut1", 64'(all_outs(1)), 64'd0);
        check("reset_outputs_dut0", 64'(all_outs(0)), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_reset", 64'(all_outs(1)), 64'd0);

        // 1: legal sentence padded with spaces
        msg = "attack at dawn";
        fill(8'h20);
        for (int i = 0; i < msg.len(); i++) mem[i] = msg[i];
        run_scan(1'b1, "t1_sentence");

        // 2: uppercase at index 0, nothing beyond address 0 read
        fill(8'h7A);
        mem[0] = 8'h41;
        run_scan(1'b1, "t2_first_byte");
        check("t2_max_address", 64'(max_addr), 64'd0);

        // 3: just-above-range byte at the last index
        fill(8'h61);
        mem[31] = 8'h7B;
        run_scan(1'b1, "t3_last_byte");

        // first illegal wins over a later one; also range edges 0x60 / 0x7A
        fill(8'h7A);
        mem[9]  = 8'h60;
        mem[20] = 8'h00;
        run_scan(1'b1, "t3b_first_wins");

        // 4: space at index 5 with and without space allowed
        fill(8'h61);
        mem[5] = 8'h20;
        run_scan(1'b0, "t4_no_space");
        run_scan(1'b1, "t4_space_ok");

        // 5: reset in the middle of a scan
        fill(8'h61);
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        check("t5_busy_before_reset", 64'(get_busy(1)), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t5_outputs_cleared", 64'(all_outs(1)), 64'd0);
        fin_seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            fin_seen = fin_seen | get_fin(1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (140) begin
            @(posedge clk);
            #1;
            fin_seen = fin_seen | get_fin(1);
        end
        check("t5_no_finish_after_abort", 64'(fin_seen), 64'd0);
        run_scan(1'b1, "t5_after_reset");

        // 6: start held high -> back-to-back scans 130 clocks apart
        fill(8'h62);
        sb.push_back(model(1'b1));
        sb.push_back(model(1'b1));
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (!get_fin(1) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        compare_result(1'b1, "t6_first", n);
        m = 0;
        idle_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            m++;
            if (!get_busy(1)) idle_cnt++;
        end while (!get_fin(1) && m < 300);
        check("t6_finish_spacing", 64'(m), 64'd130);
        check("t6_busy_low_cycles", 64'(idle_cnt), 64'd2);
        compare_result(1'b1, "t6_second", m - 2);
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t6_idle_after_release", 64'({get_busy(1), get_fin(1)}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
